gate_tt_checker: RTL and testbench
==================================

// Module: gate_tt_checker
//
// PURPOSE
// Hardware self-test engine for 2-input logic gates (xor, and, or, ...).
// Drives all four input vectors onto a gate under test and samples its
// output y. Checks y against a parameterised expected truth table and
// reports pass/fail, the error count and the first failing vector.
// Sits beside the logic_gates blocks as an on-chip check, so no simulator
// $display is needed.
//
// PARAMETERS
// TT             4'b0110  expected truth table; expected y = TT[{a,b}] (default xor)
// SETTLE_CYCLES  2        cycles a/b held before y is sampled; legal range 1..255
//
// PORTS
// clk             in   1  single clock, all logic on rising edge
// rst             in   1  synchronous, active-high reset
// start           in   1  one-cycle request to run a check; honoured only in IDLE/DONE
// y               in   1  output of the gate under test
// a               out  1  gate input a (MSB of vector)
// b               out  1  gate input b (LSB of vector)
// busy            out  1  high while a run is in progress
// done            out  1  high from end of run until next accepted start or rst
// pass            out  1  done && err_cnt==0
// err_cnt         out  3  mismatching vectors in last run, 0..4
// first_fail_vec  out  2  {a,b} of first mismatch; 2'b00 if none
// first_fail_y    out  1  y observed at first mismatch; 0 if none
//
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, vec=0, settle counter 0.
// - States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE); DONE -> SETTLE on start.
// - Accepting start (cycle 0): vec<=0, {a,b}<=2'b00, err_cnt/first_fail_* cleared,
//   done<=0, busy<=1, go to SETTLE.
// - SETTLE lasts exactly SETTLE_CYCLES cycles; a/b stay stable throughout.
// - SAMPLE lasts one cycle, with a/b unchanged. At its closing edge:
//   - compare y with TT[vec];
//   - on mismatch, err_cnt++;
//   - if this is the first mismatch, capture first_fail_vec=vec and first_fail_y=y.
// - Leaving SAMPLE:
//   - if vec!=3: vec++, {a,b}<=vec+1, return to SETTLE;
//   - if vec==3: busy<=0, done<=1, {a,b}<=2'b00, go to DONE.
// - Vector order is fixed: 00, 01, 10, 11. Each vector is held SETTLE_CYCLES+1 cycles.
// - Latency: done first reads 1 in cycle 4*(SETTLE_CYCLES+1)+1 after the start
//   cycle (default: cycle 13).
// - pass is combinational from done and err_cnt. It is never 1 while busy.
// - Boundary conditions:
//   - start while busy is ignored, with no restart or effect on counters;
//   - start in DONE begins a fresh run and clears all results;
//   - rst mid-run aborts at once to the reset state, with no done pulse;
//     results are lost;
//   - rst and start in the same cycle: rst wins, start is dropped;
//   - err_cnt cannot exceed 4, so there is no saturation logic;
//     the 3-bit width is exact.
// - y is sampled only at the SAMPLE edge. y in other cycles is don't-care,
//   so glitches while settling are tolerated.
//
// TESTING
// 1. xor gate DUT, TT=0110, S=2, start pulse -> a/b steps 00,01,10,11 each 3 cycles;
//    done=1 at cycle 13, pass=1, err_cnt=0, first_fail_vec=00.
// 2. y tied 0, TT=0110 -> err_cnt=2, pass=0, first_fail_vec=01, first_fail_y=0.
// 3. and gate DUT, TT=0110 -> mismatches at 01,10,11; err_cnt=3,
//    first_fail_vec=01, first_fail_y=0.
// 4. Start re-pulsed at cycles 3 and 9 of a run -> no effect: done still at
//    cycle 13, one vector sequence only.
// 5. rst at cycle 6 of a run -> next cycle: busy=0, done=0, a=b=0, err_cnt=0;
//    new start then completes normally at +13.
// 6. Back-to-back runs: fail run (y=0) then good xor run with start in DONE ->
//    done drops the cycle after start; second run ends err_cnt=0, pass=1.

Source files
------------

// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_tt_checker
//  Description : Built-in self-test engine for a 2-input logic gate. Drives
//                the four input vectors 00,01,10,11 onto the gate, samples
//                its output y once each vector has settled, and compares it
//                with an expected truth table. Reports pass/fail, the
//                mismatch count and the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_checker #(
    parameter logic [3:0] TT            = 4'b0110, // expected y = TT[{a,b}]
    parameter int         SETTLE_CYCLES = 2        // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [2:0] o_err_cnt,
    output logic [1:0] o_first_fail_vec,
    output logic       o_first_fail_y
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Final count value of the settle counter (counts 0..SETTLE_CYCLES-1).
    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [1:0] r_vec;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_err;
    logic [1:0] r_ffv;
    logic       r_ffy;

    logic       w_accept;
    logic       w_settle_end;
    logic       w_last_vec;
    logic       w_mismatch;

    // Start is only honoured when no run is in flight.
    assign w_accept     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_settle_end = (r_cnt == c_SETTLE_LAST);
    assign w_last_vec   = (r_vec == 2'b11);
    assign w_mismatch   = (i_y != TT[r_vec]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_end) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_next = w_last_vec ? ST_DONE : ST_SETTLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Vector sequencing, settle timing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 8'd0;
            r_vec  <= 2'b00;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 3'd0;
            r_ffv  <= 2'b00;
            r_ffy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_cnt  <= 8'd0;
                        r_vec  <= 2'b00;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_err  <= 3'd0;
                        r_ffv  <= 2'b00;
                        r_ffy  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    // Counter rearmed at zero when the settle window closes.
                    r_cnt <= w_settle_end ? 8'd0 : r_cnt + 8'd1;
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        // At most four vectors, so the 3-bit count cannot wrap.
                        r_err <= r_err + 3'd1;
                        if (r_err == 3'd0) begin
                            r_ffv <= r_vec;
                            r_ffy <= i_y;
                        end
                    end
                    r_cnt <= 8'd0;
                    if (w_last_vec) begin
                        r_vec  <= 2'b00;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_vec <= r_vec + 2'b01;
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign o_a              = r_vec[1];
    assign o_b              = r_vec[0];
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_done && (r_err == 3'd0);
    assign o_err_cnt        = r_err;
    assign o_first_fail_vec = r_ffv;
    assign o_first_fail_y   = r_ffy;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_tt_checker
//  Description : Directed self-checking bench for gate_tt_checker with a
//                selectable behavioural gate (xor / stuck-0 / and / stuck-1)
//                feeding y. Default parameters TT=0110, SETTLE_CYCLES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;

    localparam int c_MODE_XOR  = 0;
    localparam int c_MODE_ZERO = 1;
    localparam int c_MODE_AND  = 2;
    localparam int c_MODE_ONE  = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] ffv;
    logic       ffy;

    int n_assert;
    int n_fail;
    int mode;

    gate_tt_checker #(
        .TT            (4'b0110),
        .SETTLE_CYCLES (2)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (start),
        .i_y              (y),
        .o_a              (a),
        .o_b              (b),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_cnt        (err_cnt),
        .o_first_fail_vec (ffv),
        .o_first_fail_y   (ffy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate under test.
    always_comb begin
        y = 1'b0;
        case (mode)
            c_MODE_XOR:  y = a ^ b;
            c_MODE_ZERO: y = 1'b0;
            c_MODE_AND:  y = a & b;
            c_MODE_ONE:  y = 1'b1;
            default:     y = 1'b0;
        endcase
    end

    // Advance one clock; inputs and sampling happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run from a start pulse; checks the cycle-by-cycle vector
    // sequence, done at cycle 13, and the final results.
    task automatic do_run(input bit repulse, input logic [2:0] exp_err,
                          input logic [1:0] exp_ffv, input logic exp_ffy);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_c1_err_cleared", {5'd0, err_cnt}, 8'd0);
        chk("run_c1_ffv_cleared", {6'd0, ffv}, 8'd0);
        chk("run_c1_done_low", {7'd0, done}, 8'd0);
        for (int cyc = 1; cyc < 13; cyc++) begin
            chk("run_ab", {6'd0, a, b}, 8'((cyc - 1) / 3));
            chk("run_busy", {7'd0, busy}, 8'd1);
            chk("run_done", {7'd0, done}, 8'd0);
            chk("run_pass", {7'd0, pass}, 8'd0);
            start = repulse && (cyc == 3 || cyc == 9);
            step();
        end
        start = 1'b0;
        chk("end_done", {7'd0, done}, 8'd1);
        chk("end_busy", {7'd0, busy}, 8'd0);
        chk("end_ab", {6'd0, a, b}, 8'd0);
        chk("end_err", {5'd0, err_cnt}, {5'd0, exp_err});
        chk("end_pass", {7'd0, pass}, {7'd0, (exp_err == 3'd0)});
        chk("end_ffv", {6'd0, ffv}, {6'd0, exp_ffv});
        chk("end_ffy", {7'd0, ffy}, {7'd0, exp_ffy});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mode     = c_MODE_XOR;
        rst      = 1'b1;
        start    = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_pass", {7'd0, pass}, 8'd0);
        chk("rst_ab", {6'd0, a, b}, 8'd0);
        chk("rst_err", {5'd0, err_cnt}, 8'd0);
        chk("rst_ffv", {6'd0, ffv}, 8'd0);
        chk("rst_ffy", {7'd0, ffy}, 8'd0);
        rst = 1'b0;
        step();
        chk("idle_no_start", {7'd0, busy}, 8'd0);

        // Good xor gate
        mode = c_MODE_XOR;
        do_run(1'b0, 3'd0, 2'b00, 1'b0);
        step();
        chk("done_holds", {7'd0, done}, 8'd1);

        // y stuck at 0: mismatches at 01 and 10
        mode = c_MODE_ZERO;
        do_run(1'b0, 3'd2, 2'b01, 1'b0);

        // and gate: mismatches at 01, 10, 11
        mode = c_MODE_AND;
        do_run(1'b0, 3'd3, 2'b01, 1'b0);

        // y stuck at 1: mismatches at 00 and 11
        mode = c_MODE_ONE;
        do_run(1'b0, 3'd2, 2'b00, 1'b1);

        // Start re-pulsed mid-run is ignored
        mode = c_MODE_XOR;
        do_run(1'b1, 3'd0, 2'b00, 1'b0);
        step();
        chk("no_restart_after_repulse", {7'd0, busy}, 8'd0);

        // Reset mid-run (cycle 6) with start asserted together
        mode  = c_MODE_ONE;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) step();
        chk("pre_rst_err", {5'd0, err_cnt}, 8'd1);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        chk("abort_ab", {6'd0, a, b}, 8'd0);
        chk("abort_err", {5'd0, err_cnt}, 8'd0);
        chk("abort_ffy", {7'd0, ffy}, 8'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("abort_no_done", {7'd0, done}, 8'd0);
            chk("abort_start_dropped", {7'd0, busy}, 8'd0);
        end
        mode = c_MODE_XOR;
        do_run(1'b0, 3'd0, 2'b00, 1'b0);

        // Back-to-back: failing run then good run started from DONE
        mode = c_MODE_ZERO;
        do_run(1'b0, 3'd2, 2'b01, 1'b0);
        mode = c_MODE_XOR;
        do_run(1'b0, 3'd0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
